// File: rtl/cordic_arbiter_if.sv
// Bundle of requester, CORDIC-side and result signals around the shared CORDIC arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface cordic_arbiter_if #(
    parameter int width = 16,
    parameter int nreq  = 2,
    parameter int idw   = $clog2(nreq)
);
    logic [nreq-1:0]       req_valid;
    logic [nreq-1:0]       req_ready;
    logic [nreq*width-1:0] req_x0;
    logic [nreq*width-1:0] req_y0;
    logic [nreq*width-1:0] req_z0;
    logic                  cor_en;
    logic [width-1:0]      cor_x0;
    logic [width-1:0]      cor_y0;
    logic [width-1:0]      cor_z0;
    logic [width:0]        cor_x;
    logic [width:0]        cor_y;
    logic [width-1:0]      cor_z;
    logic                  out_valid;
    logic                  out_ready;
    logic [idw-1:0]        out_id;
    logic [width:0]        out_x;
    logic [width:0]        out_y;
    logic [width-1:0]      out_z;
    logic                  busy;

    modport slave (
        input  req_valid, req_x0, req_y0, req_z0, cor_x, cor_y, cor_z, out_ready,
        output req_ready, cor_en, cor_x0, cor_y0, cor_z0,
        output out_valid, out_id, out_x, out_y, out_z, busy
    );

    modport master (
        output req_valid, req_x0, req_y0, req_z0, cor_x, cor_y, cor_z, out_ready,
        input  req_ready, cor_en, cor_x0, cor_y0, cor_z0,
        input  out_valid, out_id, out_x, out_y, out_z, busy
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one pipelined CORDIC between nreq requesters, with a
// tag pipeline that returns each result to its owner; backpressure freezes the CORDIC.
module cordic_arbiter #(
    parameter int width   = 16,
    parameter int nreq    = 2,
    parameter int latency = width + 1,
    parameter int idw     = $clog2(nreq)
) (
    input  logic              clk,
    input  logic              reset,
    cordic_arbiter_if.slave   bus
);
    logic [idw-1:0]   ptr;
    logic [idw-1:0]   grant_idx;
    logic             grant_found;
    logic             accept;
    logic             cor_en;
    logic [nreq-1:0]  ready_vec;
    logic [width-1:0] op_x;
    logic [width-1:0] op_y;
    logic [width-1:0] op_z;

    // Stage 0 is loaded together with the operand registers; stages 1..latency track the
    // CORDIC's own pipeline, so stage latency lines up with cor_x/y/z.
    logic [latency:0] tag_valid;
    logic [idw-1:0]   tag_id [0:latency];

    assign cor_en = !(tag_valid[latency] && !bus.out_ready);
    assign accept = cor_en && grant_found;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= nreq; k++) begin
            if (!grant_found && bus.req_valid[(int'(ptr) + k) % nreq]) begin
                grant_found = 1'b1;
                grant_idx   = idw'((int'(ptr) + k) % nreq);
            end else begin
                grant_found = grant_found;
            end
        end
    end

    // One-hot accept strobe, gated by the CORDIC enable.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < nreq; i++) begin
            if (cor_en && grant_found && (grant_idx == idw'(i))) begin
                ready_vec[i] = 1'b1;
            end else begin
                ready_vec[i] = 1'b0;
            end
        end
    end

    // Operand registers, pointer and tag pipeline; all frozen while the output stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= idw'(nreq - 1);
            op_x      <= '0;
            op_y      <= '0;
            op_z      <= '0;
            tag_valid <= '0;
            for (int k = 0; k <= latency; k++) begin
                tag_id[k] <= '0;
            end
        end else if (cor_en) begin
            if (accept) begin
                ptr  <= grant_idx;
                op_x <= bus.req_x0[int'(grant_idx)*width +: width];
                op_y <= bus.req_y0[int'(grant_idx)*width +: width];
                op_z <= bus.req_z0[int'(grant_idx)*width +: width];
            end
            tag_valid <= {tag_valid[latency-1:0], accept};
            tag_id[0] <= grant_idx;
            for (int k = 1; k <= latency; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.cor_en    = cor_en;
    assign bus.cor_x0    = op_x;
    assign bus.cor_y0    = op_y;
    assign bus.cor_z0    = op_z;
    assign bus.out_valid = tag_valid[latency];
    assign bus.out_id    = tag_id[latency];
    assign bus.out_x     = bus.cor_x;
    assign bus.out_y     = bus.cor_y;
    assign bus.out_z     = bus.cor_z;
    assign bus.busy      = |tag_valid;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized scoreboard bench for cordic_arbiter; a stand-in CORDIC applies a simple
// invertible transform over `latency` enabled stages so every result is traceable.
module tb_cordic_arbiter;
    localparam int W   = 16;
    localparam int N   = 2;
    localparam int L   = W + 1;
    localparam int IDW = $clog2(N);

    typedef struct {
        int           id;
        logic [W:0]   x;
        logic [W:0]   y;
        logic [W-1:0] z;
    } res_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    res_t exp_q[$];
    int   cnt_q[$];
    int   m_ptr;
    logic [W-1:0] m_x0;

    cordic_arbiter_if #(.width(W), .nreq(N), .idw(IDW)) bus();

    cordic_arbiter #(.width(W), .nreq(N), .latency(L), .idw(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] fx(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a[W-1], a} + {b[W-1], b};
    endfunction

    function automatic logic [W:0] fy(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a[W-1], a} - {b[W-1], b};
    endfunction

    // Stand-in CORDIC: L enabled stages from cor_x0 to cor_x.
    logic [W:0]   px [0:L-1];
    logic [W:0]   py [0:L-1];
    logic [W-1:0] pz [0:L-1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                px[k] <= '0;
                py[k] <= '0;
                pz[k] <= '0;
            end
        end else if (bus.cor_en) begin
            px[0] <= fx(bus.cor_x0, bus.cor_y0);
            py[0] <= fy(bus.cor_x0, bus.cor_y0);
            pz[0] <= bus.cor_z0 ^ 16'h5a5a;
            for (int k = 1; k < L; k++) begin
                px[k] <= px[k-1];
                py[k] <= py[k-1];
                pz[k] <= pz[k-1];
            end
        end
    end
    assign bus.cor_x = px[L-1];
    assign bus.cor_y = py[L-1];
    assign bus.cor_z = pz[L-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict handshakes from the reference model, advance it.
    task automatic step(input logic [N-1:0] v, input logic rdy);
        logic [W-1:0] ox [N];
        logic [W-1:0] oy [N];
        logic [W-1:0] oz [N];
        bit   head;
        bit   en;
        bit   found;
        int   g;
        int   c;
        res_t r;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ox[i] = W'($urandom);
            oy[i] = W'($urandom);
            oz[i] = W'($urandom);
            bus.req_x0[i*W +: W] = ox[i];
            bus.req_y0[i*W +: W] = oy[i];
            bus.req_z0[i*W +: W] = oz[i];
        end
        bus.req_valid = v;
        bus.out_ready = rdy;
        #1;
        head  = (cnt_q.size() > 0) && (cnt_q[0] == 0);
        en    = !(head && !rdy);
        found = 1'b0;
        g     = 0;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && v[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
        end
        chk("cor_en", 32'(bus.cor_en), 32'(en));
        chk("req_ready", 32'(bus.req_ready), found ? (32'd1 << g) : 32'd0);
        chk("out_valid", 32'(bus.out_valid), 32'(head));
        chk("busy", 32'(bus.busy), 32'(cnt_q.size() > 0));
        chk("cor_x0_hold", 32'(bus.cor_x0), 32'(m_x0));
        @(posedge clk);
        if (en) begin
            if (head) void'(cnt_q.pop_front());
            foreach (cnt_q[i]) if (cnt_q[i] > 0) cnt_q[i]--;
            if (found) begin
                cnt_q.push_back(L);
                r.id = g;
                r.x  = fx(ox[g], oy[g]);
                r.y  = fy(ox[g], oy[g]);
                r.z  = oz[g] ^ 16'h5a5a;
                exp_q.push_back(r);
                m_ptr = g;
                m_x0  = ox[g];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1);
    endtask

    task automatic wait_head();
        int t;
        t = 0;
        while (!((cnt_q.size() > 0) && (cnt_q[0] == 0)) && t < 40) begin
            step('0, 1'b1);
            t++;
        end
        chk("head_timeout", 32'(t < 40), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cor_x0", 32'(bus.cor_x0), 32'd0);
        exp_q.delete();
        cnt_q.delete();
        m_ptr = N - 1;
        m_x0  = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks that stalled outputs hold.
    initial begin : monitor
        bit           prev_stall;
        logic [W:0]   sx;
        logic [W:0]   sy;
        logic [W-1:0] sz;
        logic [IDW-1:0] sid;
        res_t         e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (prev_stall && !reset) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_x", 32'(bus.out_x), 32'(sx));
                chk("stall_y", 32'(bus.out_y), 32'(sy));
                chk("stall_z", 32'(bus.out_z), 32'(sz));
                chk("stall_id", 32'(bus.out_id), 32'(sid));
            end
            if (bus.out_valid && bus.out_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("stale_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_id", 32'(bus.out_id), 32'(e.id));
                    chk("out_x", 32'(bus.out_x), 32'(e.x));
                    chk("out_y", 32'(bus.out_y), 32'(e.y));
                    chk("out_z", 32'(bus.out_z), 32'(e.z));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !reset;
            sx  = bus.out_x;
            sy  = bus.out_y;
            sz  = bus.out_z;
            sid = bus.out_id;
        end
    end

    initial begin : stimulus
        int t;
        checks = 0;
        errors = 0;
        m_ptr  = N - 1;
        m_x0   = '0;
        reset  = 1'b1;
        bus.req_valid = '0;
        bus.req_x0    = '0;
        bus.req_y0    = '0;
        bus.req_z0    = '0;
        bus.out_ready = 1'b1;
        #3;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_cor_en", 32'(bus.cor_en), 32'd1);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_cor_x0", 32'(bus.cor_x0), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single request from requester 0
        step(2'b01, 1'b1);
        idle(22);
        // fairness: both requesters held valid
        for (int i = 0; i < 8; i++) step(2'b11, 1'b1);
        idle(22);
        // backpressure: stall for 3 cycles when the first result appears
        for (int i = 0; i < 5; i++) step(2'b01, 1'b1);
        wait_head();
        for (int i = 0; i < 3; i++) step(2'b01, 1'b0);
        idle(22);
        // bubbles: requester 1 every third cycle
        for (int i = 0; i < 6; i++) begin
            step(2'b10, 1'b1);
            step(2'b00, 1'b1);
            step(2'b00, 1'b1);
        end
        idle(22);
        // reset with samples in flight; next grant must be requester 0
        for (int i = 0; i < 4; i++) step(2'b11, 1'b1);
        do_reset();
        step(2'b11, 1'b1);
        idle(24);
        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        t = 0;
        while (cnt_q.size() > 0 && t < 200) begin
            step('0, 1'b1);
            t++;
        end
        idle(2);
        chk("drain_model", 32'(cnt_q.size()), 32'd0);
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
